// File: rtl/decode_stage.sv
// RV32I decode stage: one pipeline register fed by fetch, field decode, regfile read and load-use stall.
// Define DECODE_FWD_EN to add EX/MEM operand bypass ports; the default build reads operands from the regfile only.
module decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid_i,
    input  logic [XLEN+31:0]  f_to_d_bus,
    output logic              stall_fetch,
    input  logic              bj_taken_i,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_ready_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
`ifdef DECODE_FWD_EN
    input  logic              ex_fwd_en_i,
    input  logic [4:0]        ex_fwd_rd_i,
    input  logic [XLEN-1:0]   ex_fwd_data_i,
    input  logic              mem_fwd_en_i,
    input  logic [4:0]        mem_fwd_rd_i,
    input  logic [XLEN-1:0]   mem_fwd_data_i,
`endif
    output logic              d_valid_o,
    output logic [XLEN-1:0]   d_pc_o,
    output logic [XLEN-1:0]   d_imm_o,
    output logic [XLEN-1:0]   d_rs1_val_o,
    output logic [XLEN-1:0]   d_rs2_val_o,
    output logic [4:0]        d_rd_o,
    output logic [5:0]        d_op_o,
    output logic [3:0]        d_funct_o
);

    localparam logic [5:0] OP_ALU_R   = 6'd0;
    localparam logic [5:0] OP_ALU_I   = 6'd1;
    localparam logic [5:0] OP_LOAD    = 6'd2;
    localparam logic [5:0] OP_STORE   = 6'd3;
    localparam logic [5:0] OP_BRANCH  = 6'd4;
    localparam logic [5:0] OP_JAL     = 6'd5;
    localparam logic [5:0] OP_JALR    = 6'd6;
    localparam logic [5:0] OP_LUI     = 6'd7;
    localparam logic [5:0] OP_AUIPC   = 6'd8;
    localparam logic [5:0] OP_ILLEGAL = 6'h3f;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic            vld_p0;
    logic [XLEN-1:0] pc_p0;
    logic [31:0]     inst_p0;

    logic [5:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs2_used;
    logic       hazard;
    logic       allowin;

    function automatic logic signed [31:0] imm_gen(input logic [31:0] inst, input logic [5:0] cls);
        logic signed [31:0] imm;
        case (cls)
            OP_ALU_I, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:                   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:                  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           imm = {inst[31:12], 12'h000};
            OP_JAL:                     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:                    imm = '0;
        endcase
        return imm;
    endfunction

`ifdef DECODE_FWD_EN
    // x0 wins, then the younger EX result, then MEM, then the regfile.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_en,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data
    );
        if (addr == 5'd0)
            return '0;
        if (ex_en && ex_rd != 5'd0 && ex_rd == addr)
            return ex_data;
        if (mem_en && mem_rd != 5'd0 && mem_rd == addr)
            return mem_data;
        return rf_data;
    endfunction
`else
    function automatic logic [XLEN-1:0] select_operand(input logic [4:0] addr, input logic [XLEN-1:0] rf_data);
        if (addr == 5'd0)
            return '0;
        return rf_data;
    endfunction
`endif

    // ---- stage p0: fetch-to-decode pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            pc_p0   <= RESET_PC;
            inst_p0 <= INST_NOP;
        end else if (bj_taken_i) begin
            vld_p0 <= 1'b0;
        end else if (allowin) begin
            vld_p0 <= f_valid_i;
            if (f_valid_i) begin
                pc_p0   <= f_to_d_bus[XLEN+31:32];
                inst_p0 <= f_to_d_bus[31:0];
            end
        end
    end

    // ---- decode of the registered instruction, combinational to execute
    always_comb begin
        op = OP_ILLEGAL;
        case (inst_p0[6:0])
            7'b0110011: op = OP_ALU_R;
            7'b0010011: op = OP_ALU_I;
            7'b0000011: op = OP_LOAD;
            7'b0100011: op = OP_STORE;
            7'b1100011: op = OP_BRANCH;
            7'b1101111: op = OP_JAL;
            7'b1100111: op = OP_JALR;
            7'b0110111: op = OP_LUI;
            7'b0010111: op = OP_AUIPC;
            default:    op = OP_ILLEGAL;
        endcase
    end

    assign rs1       = inst_p0[19:15];
    assign rs2       = inst_p0[24:20];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    assign rs2_used  = (op == OP_ALU_R) || (op == OP_STORE) || (op == OP_BRANCH);

    // rs1 is compared for every class; only R/S/B actually read rs2.
    assign hazard = vld_p0 && ex_is_load_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == rs1) || (rs2_used && (ex_rd_i == rs2)));

    assign allowin     = !vld_p0 || (ex_ready_i && !hazard);
    assign stall_fetch = !allowin;

    assign d_valid_o = vld_p0 && !hazard && !bj_taken_i;
    assign d_pc_o    = pc_p0;
    assign d_imm_o   = imm_gen(inst_p0, op);
    assign d_op_o    = op;
    assign d_funct_o = {inst_p0[30], inst_p0[14:12]};
    assign d_rd_o    = ((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_ILLEGAL)) ? 5'd0 : inst_p0[11:7];

`ifdef DECODE_FWD_EN
    assign d_rs1_val_o = select_operand(rs1, rf_rdata1, ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i,
                                        mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i);
    assign d_rs2_val_o = select_operand(rs2, rf_rdata2, ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i,
                                        mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i);
`else
    assign d_rs1_val_o = select_operand(rs1, rf_rdata1);
    assign d_rs2_val_o = select_operand(rs2, rf_rdata2);
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a spec-level model checked every cycle plus literal expectations.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    localparam logic [5:0] OP_ALU_R   = 6'd0;
    localparam logic [5:0] OP_ALU_I   = 6'd1;
    localparam logic [5:0] OP_LOAD    = 6'd2;
    localparam logic [5:0] OP_STORE   = 6'd3;
    localparam logic [5:0] OP_BRANCH  = 6'd4;
    localparam logic [5:0] OP_JAL     = 6'd5;
    localparam logic [5:0] OP_JALR    = 6'd6;
    localparam logic [5:0] OP_LUI     = 6'd7;
    localparam logic [5:0] OP_AUIPC   = 6'd8;
    localparam logic [5:0] OP_ILLEGAL = 6'h3f;

    localparam logic [31:0] I_ADDI5 = 32'h0050_0093;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_LUI   = 32'h1234_50B7;
    localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid_i;
    logic [63:0] f_to_d_bus;
    logic        stall_fetch;
    logic        bj_taken_i;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_ready_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_i;
    logic        d_valid_o;
    logic [31:0] d_pc_o, d_imm_o, d_rs1_val_o, d_rs2_val_o;
    logic [4:0]  d_rd_o;
    logic [5:0]  d_op_o;
    logic [3:0]  d_funct_o;
`ifdef DECODE_FWD_EN
    logic        ex_fwd_en_i, mem_fwd_en_i;
    logic [4:0]  ex_fwd_rd_i, mem_fwd_rd_i;
    logic [31:0] ex_fwd_data_i, mem_fwd_data_i;
`endif

    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;
    logic        checking;

    logic        m_vld;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    logic [31:0] prog [8];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .f_valid_i(f_valid_i), .f_to_d_bus(f_to_d_bus),
        .stall_fetch(stall_fetch), .bj_taken_i(bj_taken_i),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_ready_i(ex_ready_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
`ifdef DECODE_FWD_EN
        .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_rd_i(ex_fwd_rd_i), .ex_fwd_data_i(ex_fwd_data_i),
        .mem_fwd_en_i(mem_fwd_en_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
`endif
        .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_imm_o(d_imm_o),
        .d_rs1_val_o(d_rs1_val_o), .d_rs2_val_o(d_rs2_val_o),
        .d_rd_o(d_rd_o), .d_op_o(d_op_o), .d_funct_o(d_funct_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Instruction meaning computed by field weights rather than bit concatenation.
    function automatic void mdecode(input logic [31:0] i, output logic [5:0] op, output logic [31:0] imm,
                                    output logic [4:0] rd, output logic u2);
        int v;
        v  = 0;
        u2 = 1'b0;
        op = OP_ILLEGAL;
        case (i[6:0])
            7'h33: begin op = OP_ALU_R; u2 = 1'b1; end
            7'h13, 7'h03, 7'h67: begin
                op = (i[6:0] == 7'h13) ? OP_ALU_I : (i[6:0] == 7'h03) ? OP_LOAD : OP_JALR;
                v = int'(i[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                op = OP_STORE; u2 = 1'b1;
                v = int'(i[31:25]) * 32 + int'(i[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                op = OP_BRANCH; u2 = 1'b1;
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            7'h6F: begin
                op = OP_JAL;
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (i[31]) v -= (1 << 20);
            end
            7'h37: op = OP_LUI;
            7'h17: op = OP_AUIPC;
            default: op = OP_ILLEGAL;
        endcase
        imm = v;
        if (op == OP_LUI || op == OP_AUIPC) imm = i & 32'hFFFF_F000;
        rd = (op == OP_STORE || op == OP_BRANCH || op == OP_ILLEGAL) ? 5'd0 : i[11:7];
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_FWD_EN
        if (ex_fwd_en_i && ex_fwd_rd_i == a) return ex_fwd_data_i;
        if (mem_fwd_en_i && mem_fwd_rd_i == a) return mem_fwd_data_i;
`endif
        return rf[a];
    endfunction

    function automatic logic m_hazard();
        logic [5:0] op; logic [31:0] imm; logic [4:0] rd; logic u2;
        mdecode(m_inst, op, imm, rd, u2);
        return m_vld && ex_is_load_i && ex_rd_i != 5'd0 &&
               (ex_rd_i == m_inst[19:15] || (u2 && ex_rd_i == m_inst[24:20]));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_vld  <= 1'b0;
            m_pc   <= RST_PC;
            m_inst <= 32'h0000_0013;
        end else if (bj_taken_i) begin
            m_vld <= 1'b0;
        end else if (!m_vld || (ex_ready_i && !m_hazard())) begin
            m_vld <= f_valid_i;
            if (f_valid_i) begin
                m_pc   <= f_to_d_bus[63:32];
                m_inst <= f_to_d_bus[31:0];
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        u2, hz, ev;
        if (checking && !reset) begin
            mdecode(m_inst, op, imm, rd, u2);
            hz = m_hazard();
            ev = m_vld && !hz && !bj_taken_i;
            chk("m_valid", {31'd0, d_valid_o}, {31'd0, ev});
            chk("m_stall", {31'd0, stall_fetch}, {31'd0, !(!m_vld || (ex_ready_i && !hz))});
            if (m_vld) begin
                chk("m_raddr1", {27'd0, rf_raddr1}, {27'd0, m_inst[19:15]});
                chk("m_raddr2", {27'd0, rf_raddr2}, {27'd0, m_inst[24:20]});
            end
            if (ev) begin
                chk("m_pc", d_pc_o, m_pc);
                chk("m_imm", d_imm_o, imm);
                chk("m_rd", {27'd0, d_rd_o}, {27'd0, rd});
                chk("m_op", {26'd0, d_op_o}, {26'd0, op});
                chk("m_funct", {28'd0, d_funct_o}, {28'd0, m_inst[30], m_inst[14:12]});
                chk("m_rs1", d_rs1_val_o, m_operand(m_inst[19:15]));
                chk("m_rs2", d_rs2_val_o, m_operand(m_inst[24:20]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        f_valid_i  = 1'b1;
        f_to_d_bus = {pc, inst};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; f_valid_i = 1'b0; f_to_d_bus = '0; bj_taken_i = 1'b0;
        ex_ready_i = 1'b1; ex_is_load_i = 1'b0; ex_rd_i = '0; checking = 1'b0;
`ifdef DECODE_FWD_EN
        ex_fwd_en_i = 1'b0; ex_fwd_rd_i = '0; ex_fwd_data_i = '0;
        mem_fwd_en_i = 1'b0; mem_fwd_rd_i = '0; mem_fwd_data_i = '0;
`endif
        for (int r = 0; r < 32; r++) rf[r] = 32'h100 + r;
        rf[0] = 32'hDEAD_BEEF; rf[1] = 32'd11; rf[2] = 32'd22;
        prog[0] = 32'h0080_00EF; prog[1] = 32'h0000_80E7; prog[2] = 32'h0020_A223; prog[3] = 32'h0040_A183;
        prog[4] = 32'h0000_1117; prog[5] = 32'h4020_81B3; prog[6] = 32'hFFF0_0093; prog[7] = 32'hFE20_AE23;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, d_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_fetch}, 32'd0);
        chk("rst_pc", d_pc_o, RST_PC);

        next_cycle(); reset = 1'b0; checking = 1'b1; fetch(32'h0, I_ADDI5);
        next_cycle(); fetch(32'h4, I_ADD);
        @(negedge clk);
        chk("addi_valid", {31'd0, d_valid_o}, 32'd1);
        chk("addi_op", {26'd0, d_op_o}, {26'd0, OP_ALU_I});
        chk("addi_imm", d_imm_o, 32'd5);
        chk("addi_rd", {27'd0, d_rd_o}, 32'd1);
        chk("addi_rs1_x0", d_rs1_val_o, 32'd0);

        next_cycle(); ex_ready_i = 1'b0; fetch(32'h8, I_LUI);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stall", {31'd0, stall_fetch}, 32'd1);
            chk("bp_pc", d_pc_o, 32'h4);
            if (k == 0) begin
                chk("add_rs1", d_rs1_val_o, 32'd11);
                chk("add_rs2", d_rs2_val_o, 32'd22);
                chk("add_rd", {27'd0, d_rd_o}, 32'd3);
            end
            next_cycle();
        end
        ex_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'd0, stall_fetch}, 32'd0);

        next_cycle(); fetch(32'hC, I_ADD);
        @(negedge clk);
        chk("lui_pc", d_pc_o, 32'h8);
        chk("lui_imm", d_imm_o, 32'h1234_5000);
        chk("lui_op", {26'd0, d_op_o}, {26'd0, OP_LUI});

        next_cycle(); ex_is_load_i = 1'b1; ex_rd_i = 5'd2; fetch(32'h10, I_BEQ);
        @(negedge clk);
        chk("lu_valid", {31'd0, d_valid_o}, 32'd0);
        chk("lu_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle(); ex_is_load_i = 1'b0;
        @(negedge clk);
        chk("lu_issue", {31'd0, d_valid_o}, 32'd1);
        chk("lu_pc", d_pc_o, 32'hC);

        next_cycle(); fetch(32'h14, I_ADDI5);
        @(negedge clk);
        chk("beq_imm", d_imm_o, 32'hFFFF_FFFC);
        chk("beq_rd", {27'd0, d_rd_o}, 32'd0);
        chk("beq_op", {26'd0, d_op_o}, {26'd0, OP_BRANCH});

        next_cycle(); bj_taken_i = 1'b1; ex_ready_i = 1'b0; fetch(32'h18, I_LUI);
        @(negedge clk);
        chk("flush_mask", {31'd0, d_valid_o}, 32'd0);
        next_cycle(); bj_taken_i = 1'b0; ex_ready_i = 1'b1; fetch(32'h1C, 32'h0);
        @(negedge clk);
        chk("flush_valid", {31'd0, d_valid_o}, 32'd0);
        chk("flush_stall", {31'd0, stall_fetch}, 32'd0);

        next_cycle(); fetch(32'h20, I_ADDI5); ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
        @(negedge clk);
        chk("ill_valid", {31'd0, d_valid_o}, 32'd1);
        chk("ill_op", {26'd0, d_op_o}, {26'd0, OP_ILLEGAL});
        chk("ill_rd", {27'd0, d_rd_o}, 32'd0);
        next_cycle(); f_valid_i = 1'b0;
        @(negedge clk);
        chk("itype_no_rs2_haz", {31'd0, d_valid_o}, 32'd1);

        next_cycle(); ex_is_load_i = 1'b0; fetch(32'h24, I_ADD);
        next_cycle(); ex_ready_i = 1'b0; f_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stall_fetch}, 32'd1);
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, d_valid_o}, 32'd0);
        chk("midrst_stall", {31'd0, stall_fetch}, 32'd0);
        chk("midrst_pc", d_pc_o, RST_PC);

        for (int k = 0; k < 16; k++) begin
            next_cycle();
            fetch(32'h100 + 32'(k * 4), prog[k % 8]);
            ex_ready_i   = (k % 3) != 2;
            ex_is_load_i = (k % 4) == 1;
            ex_rd_i      = 5'(k % 4);
        end
        next_cycle(); f_valid_i = 1'b0; ex_ready_i = 1'b1; ex_is_load_i = 1'b0;

`ifdef DECODE_FWD_EN
        next_cycle();
        ex_fwd_en_i = 1'b1; ex_fwd_rd_i = 5'd1; ex_fwd_data_i = 32'd7;
        mem_fwd_en_i = 1'b1; mem_fwd_rd_i = 5'd1; mem_fwd_data_i = 32'd9;
        fetch(32'h200, 32'h0010_81B3);
        next_cycle(); f_valid_i = 1'b0;
        @(negedge clk);
        chk("fwd_rs1", d_rs1_val_o, 32'd7);
        chk("fwd_rs2", d_rs2_val_o, 32'd7);
        next_cycle(); ex_fwd_rd_i = 5'd0; mem_fwd_en_i = 1'b0; fetch(32'h204, 32'h0000_0033);
        next_cycle(); f_valid_i = 1'b0;
        @(negedge clk);
        chk("fwd_x0", d_rs1_val_o, 32'd0);
        next_cycle(); ex_fwd_en_i = 1'b0;
`endif

        repeat (3) next_cycle();
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
